// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - instruction memory with streaming load port and registered fetch port
module imem_ctrl #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] NOP_INST  = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              ld_done_o,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic              if_stall_i,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_valid_o,
  output logic              if_err_o,
  output logic              busy_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] ld_off;
  logic [ADDR_W-1:0] if_off;
  logic [IDX_W-1:0]  ld_word;
  logic [IDX_W-1:0]  if_word;
  logic              ld_hs;
  logic              fetch_acc;
  logic              fetch_err;

  // Byte offsets from the memory base become word indices, truncated to the memory size.
  assign ld_off  = ld_addr_i - BASE_ADDR;
  assign if_off  = if_pc_i - BASE_ADDR;
  assign ld_word = IDX_W'(ld_off >> 2);
  assign if_word = IDX_W'(if_off >> 2);

  assign ld_hs     = ld_valid_i && ld_ready_o;
  // Fetches only happen in IDLE, so a load write and a fetch read never share a cycle.
  assign fetch_acc = (state == IDLE) && if_req_i && !if_stall_i && !ld_start_i;
  assign fetch_err = (if_pc_i[1:0] != 2'b00) || (if_pc_i < BASE_ADDR) ||
                     ((if_off >> (IDX_W + 2)) != '0);

  // Session state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Session next-state and status outputs.
  always_comb begin
    state_nxt  = state;
    ld_ready_o = 1'b0;
    ld_done_o  = 1'b0;
    busy_o     = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start_i) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        ld_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (ld_valid_i && ld_last_i) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ld_done_o = 1'b1;
        busy_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Load pointer: seeded at session start, advances (and wraps) on every accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_idx <= '0;
    end else if (state == IDLE && ld_start_i) begin
      ld_idx <= ld_word;
    end else if (ld_hs) begin
      ld_idx <= ld_idx + 1'b1;
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_hs) begin
      mem[ld_idx] <= ld_data_i;
    end
  end

  // Registered fetch result; frozen while the pipeline stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_inst_o  <= NOP_INST;
      if_valid_o <= 1'b0;
      if_err_o   <= 1'b0;
    end else if (!if_stall_i) begin
      if (fetch_acc) begin
        if_valid_o <= 1'b1;
        if_err_o   <= fetch_err;
        if_inst_o  <= fetch_err ? NOP_INST : mem[if_word];
      end else begin
        if_valid_o <= 1'b0;
        if_err_o   <= 1'b0;
      end
    end
  end

endmodule
